// File: rtl/xadc_drp_package.sv
// Shared DRP geometry, XADC channel addresses and sequencer state type.
package xadc_drp_package;

    localparam int XADC_DRP_DATA_WIDTH      = 16;
    localparam int XADC_DRP_AXIS_ADDR_WIDTH = 7;
    localparam int XADC_SAMPLE_WIDTH        = 12;

    // vaux4 carries the current sense, vaux12 the voltage sense
    localparam logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] XADC_DRP_ADDR_CURRENT_CHANNEL = 7'h14;
    localparam logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] XADC_DRP_ADDR_VOLTAGE_CHANNEL = 7'h1C;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HOST_ISSUE = 3'd1,
        HOST_WAIT  = 3'd2,
        CUR_ISSUE  = 3'd3,
        CUR_WAIT   = 3'd4,
        VOLT_ISSUE = 3'd5,
        VOLT_WAIT  = 3'd6
    } drp_state_t;

    // The 12-bit XADC result sits left-justified in the 16-bit DRP word
    function automatic logic [XADC_SAMPLE_WIDTH-1:0] drp_result(
        input logic [XADC_DRP_DATA_WIDTH-1:0] word
    );
        return word[15:4];
    endfunction

endpackage

// File: rtl/xadc_drp_sequencer.sv
// On every XADC end-of-sequence, reads the current and voltage channels over
// DRP and presents them as a valid/ready sample pair; idle DRP slots are lent
// to a host port. Each DRP wait is guarded by a cycle timeout.
module xadc_drp_sequencer
    import xadc_drp_package::*;
#(
    parameter int DRDY_TIMEOUT   = 64,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                                dclk_in,
    input  logic                                reset_n_in,
    input  logic                                eos_in,
    input  logic                                busy_in,
    output logic                                den_out,
    output logic                                dwe_out,
    output logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] daddr_out,
    output logic [XADC_DRP_DATA_WIDTH-1:0]      di_out,
    input  logic                                drdy_in,
    input  logic [XADC_DRP_DATA_WIDTH-1:0]      do_in,
    input  logic                                host_req_in,
    input  logic                                host_we_in,
    input  logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] host_addr_in,
    input  logic [XADC_DRP_DATA_WIDTH-1:0]      host_di_in,
    output logic                                host_ack_out,
    output logic [XADC_DRP_DATA_WIDTH-1:0]      host_do_out,
    output logic [XADC_SAMPLE_WIDTH-1:0]        cur_sample_out,
    output logic [XADC_SAMPLE_WIDTH-1:0]        volt_sample_out,
    output logic                                sample_valid_out,
    input  logic                                sample_ready_in,
    output logic                                timeout_err_out,
    output logic [DROP_CNT_WIDTH-1:0]           dropped_cnt_out
);

    localparam int TMO_WIDTH = $clog2(DRDY_TIMEOUT + 1);
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(DRDY_TIMEOUT - 1);

    drp_state_t                        state_reg, state_next;
    logic                              pending_reg;
    logic [TMO_WIDTH-1:0]              timeout_cnt_reg;
    logic [XADC_SAMPLE_WIDTH-1:0]      cur_hold_reg;
    logic [XADC_SAMPLE_WIDTH-1:0]      cur_sample_reg;
    logic [XADC_SAMPLE_WIDTH-1:0]      volt_sample_reg;
    logic                              sample_valid_reg;
    logic                              host_ack_reg;
    logic [XADC_DRP_DATA_WIDTH-1:0]    host_do_reg;
    logic                              timeout_err_reg;
    logic [DROP_CNT_WIDTH-1:0]         dropped_cnt_reg;

    logic in_wait;
    logic wait_expired;
    logic out_free;
    logic busy_unused;

    assign busy_unused  = busy_in;
    assign in_wait      = (state_reg == HOST_WAIT) || (state_reg == CUR_WAIT) ||
                          (state_reg == VOLT_WAIT);
    assign wait_expired = in_wait && !drdy_in && (timeout_cnt_reg == TMO_LAST);
    assign out_free     = !sample_valid_reg || sample_ready_in;

    // State register
    always_ff @(posedge dclk_in) begin
        if (!reset_n_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and DRP request drive
    always_comb begin
        state_next = state_reg;
        den_out    = 1'b0;
        dwe_out    = 1'b0;
        daddr_out  = '0;
        di_out     = '0;
        unique case (state_reg)
            IDLE: begin
                // A host grant is withheld while an eos is arriving so that a
                // sequence raised in the same cycle still goes first, and in the
                // ack cycle because the host only drops its request after ack.
                if (pending_reg && out_free) begin
                    state_next = CUR_ISSUE;
                end else if (host_req_in && !eos_in && !host_ack_reg) begin
                    state_next = HOST_ISSUE;
                end
            end
            HOST_ISSUE: begin
                den_out    = 1'b1;
                dwe_out    = host_we_in;
                daddr_out  = host_addr_in;
                di_out     = host_di_in;
                state_next = HOST_WAIT;
            end
            HOST_WAIT: begin
                if (drdy_in || wait_expired) begin
                    state_next = IDLE;
                end
            end
            CUR_ISSUE: begin
                den_out    = 1'b1;
                daddr_out  = XADC_DRP_ADDR_CURRENT_CHANNEL;
                state_next = CUR_WAIT;
            end
            CUR_WAIT: begin
                if (drdy_in) begin
                    state_next = VOLT_ISSUE;
                end else if (wait_expired) begin
                    state_next = IDLE;
                end
            end
            VOLT_ISSUE: begin
                den_out    = 1'b1;
                daddr_out  = XADC_DRP_ADDR_VOLTAGE_CHANNEL;
                state_next = VOLT_WAIT;
            end
            VOLT_WAIT: begin
                if (drdy_in || wait_expired) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pending sequence flag and saturating count of events lost while pending
    always_ff @(posedge dclk_in) begin
        if (!reset_n_in) begin
            pending_reg     <= 1'b0;
            dropped_cnt_reg <= '0;
        end else begin
            // An eos landing in CUR_ISSUE refills the flag being consumed there
            if (eos_in && pending_reg && (state_reg != CUR_ISSUE) &&
                (dropped_cnt_reg != {DROP_CNT_WIDTH{1'b1}})) begin
                dropped_cnt_reg <= dropped_cnt_reg + 1'b1;
            end
            if (eos_in) begin
                pending_reg <= 1'b1;
            end else if (state_reg == CUR_ISSUE) begin
                pending_reg <= 1'b0;
            end
        end
    end

    // Wait-cycle counter, restarted whenever the machine is outside a wait
    always_ff @(posedge dclk_in) begin
        if (!reset_n_in) begin
            timeout_cnt_reg <= '0;
        end else if (in_wait) begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
        end else begin
            timeout_cnt_reg <= '0;
        end
    end

    // Sample capture and valid/ready output register
    always_ff @(posedge dclk_in) begin
        if (!reset_n_in) begin
            cur_hold_reg     <= '0;
            cur_sample_reg   <= '0;
            volt_sample_reg  <= '0;
            sample_valid_reg <= 1'b0;
        end else begin
            if ((state_reg == CUR_WAIT) && drdy_in) begin
                cur_hold_reg <= drp_result(do_in);
            end
            if ((state_reg == VOLT_WAIT) && drdy_in) begin
                cur_sample_reg   <= cur_hold_reg;
                volt_sample_reg  <= drp_result(do_in);
                sample_valid_reg <= 1'b1;
            end else if (sample_ready_in) begin
                sample_valid_reg <= 1'b0;
            end
        end
    end

    // Host completion: read data (zero on timeout) and a one-cycle ack
    always_ff @(posedge dclk_in) begin
        if (!reset_n_in) begin
            host_ack_reg <= 1'b0;
            host_do_reg  <= '0;
        end else begin
            host_ack_reg <= 1'b0;
            if (state_reg == HOST_WAIT) begin
                if (drdy_in) begin
                    host_ack_reg <= 1'b1;
                    host_do_reg  <= do_in;
                end else if (wait_expired) begin
                    host_ack_reg <= 1'b1;
                    host_do_reg  <= '0;
                end
            end
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge dclk_in) begin
        if (!reset_n_in) begin
            timeout_err_reg <= 1'b0;
        end else if (wait_expired) begin
            timeout_err_reg <= 1'b1;
        end
    end

    assign host_ack_out     = host_ack_reg;
    assign host_do_out      = host_do_reg;
    assign cur_sample_out   = cur_sample_reg;
    assign volt_sample_out  = volt_sample_reg;
    assign sample_valid_out = sample_valid_reg;
    assign timeout_err_out  = timeout_err_reg;
    assign dropped_cnt_out  = dropped_cnt_reg;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Directed bench: DRP responder answering 3 cycles after den, immediate
// assertions on every observation, one summary line at the end.
module tb_xadc_drp_sequencer;
    import xadc_drp_package::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        eos = 1'b0, busy = 1'b0;
    logic        den_out, dwe_out;
    logic [6:0]  daddr_out;
    logic [15:0] di_out;
    logic        drdy = 1'b0;
    logic [15:0] do_data = 16'h0;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [6:0]  host_addr = 7'h0;
    logic [15:0] host_di = 16'h0;
    logic        host_ack_out;
    logic [15:0] host_do_out;
    logic [11:0] cur_sample_out, volt_sample_out;
    logic        sample_valid_out;
    logic        sample_ready = 1'b1;
    logic        timeout_err_out;
    logic [7:0]  dropped_cnt_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xadc_drp_sequencer #(.DRDY_TIMEOUT(64), .DROP_CNT_WIDTH(8)) dut (
        .dclk_in(clk), .reset_n_in(reset_n), .eos_in(eos), .busy_in(busy),
        .den_out(den_out), .dwe_out(dwe_out), .daddr_out(daddr_out), .di_out(di_out),
        .drdy_in(drdy), .do_in(do_data),
        .host_req_in(host_req), .host_we_in(host_we), .host_addr_in(host_addr),
        .host_di_in(host_di), .host_ack_out(host_ack_out), .host_do_out(host_do_out),
        .cur_sample_out(cur_sample_out), .volt_sample_out(volt_sample_out),
        .sample_valid_out(sample_valid_out), .sample_ready_in(sample_ready),
        .timeout_err_out(timeout_err_out), .dropped_cnt_out(dropped_cnt_out)
    );

    // DRP responder: drdy with data exactly 3 cycles after den; not reset by the DUT reset
    logic       resp_en = 1'b1;
    logic [1:0] den_pipe = 2'b00;
    logic [6:0] addr_p0 = 7'h0, addr_p1 = 7'h0;

    function automatic logic [15:0] resp_data(input logic [6:0] a);
        if (a == 7'h14) return 16'h007F;
        if (a == 7'h1C) return 16'h00FF;
        return 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        den_pipe[0] <= den_out && resp_en;
        addr_p0     <= daddr_out;
        den_pipe[1] <= den_pipe[0];
        addr_p1     <= addr_p0;
        drdy        <= den_pipe[1];
        do_data     <= den_pipe[1] ? resp_data(addr_p1) : 16'h0000;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_eos();
        eos = 1'b1;
        step();
        eos = 1'b0;
    endtask

    task automatic wait_den(input string tag, input logic [6:0] addr, input logic we, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!den_out && n < budget);
        check({tag, "_den"}, 64'(den_out), 64'd1);
        check({tag, "_addr"}, 64'(daddr_out), 64'(addr));
        check({tag, "_dwe"}, 64'(dwe_out), 64'(we));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!sample_valid_out && n < budget) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 64'(sample_valid_out), 64'd1);
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int n = 0;
        while (!host_ack_out && n < budget) begin
            step();
            n++;
        end
        check({tag, "_ack"}, 64'(host_ack_out), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_drp_host"}, 64'({den_out, dwe_out, daddr_out, di_out, host_ack_out, host_do_out}), 64'd0);
        check({tag, "_sample_stat"}, 64'({cur_sample_out, volt_sample_out, sample_valid_out,
                                          timeout_err_out, dropped_cnt_out}), 64'd0);
    endtask

    initial begin
        int n;
        int den_seen;

        // Reset state
        repeat (3) step();
        check_all_zero("reset");
        $display("txn reset: outputs cleared");
        reset_n = 1'b1;
        step();

        // Basic sequence: exact latencies eos->den, den->den, drdy->valid
        pulse_eos();
        check("lat_n1_den", 64'(den_out), 64'd0);
        step();
        check("lat_n2_den", 64'(den_out), 64'd1);
        check("lat_n2_addr", 64'(daddr_out), 64'h14);
        check("lat_n2_dwe", 64'(dwe_out), 64'd0);
        n = 0;
        do begin step(); n++; end while (!den_out && n < 20);
        check("volt_den_gap", 64'(n), 64'd4);
        check("volt_addr", 64'(daddr_out), 64'h1C);
        n = 0;
        do begin step(); n++; end while (!sample_valid_out && n < 20);
        check("valid_gap", 64'(n), 64'd4);
        check("basic_cur", 64'(cur_sample_out), 64'h007);
        check("basic_volt", 64'(volt_sample_out), 64'h00F);
        step();
        check("basic_valid_one_cycle", 64'(sample_valid_out), 64'd0);
        $display("txn basic: cur=%h volt=%h", cur_sample_out, volt_sample_out);

        // Backpressure: held sample, blocked second sequence, dropped third eos
        sample_ready = 1'b0;
        pulse_eos();
        wait_valid("bp_first", 30);
        check("bp_cur", 64'(cur_sample_out), 64'h007);
        pulse_eos();
        den_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (den_out) den_seen++;
        end
        check("bp_no_den", 64'(den_seen), 64'd0);
        check("bp_valid_held", 64'(sample_valid_out), 64'd1);
        check("bp_volt_held", 64'(volt_sample_out), 64'h00F);
        check("bp_dropped_zero", 64'(dropped_cnt_out), 64'd0);
        pulse_eos();
        check("bp_dropped_one", 64'(dropped_cnt_out), 64'd1);
        sample_ready = 1'b1;
        step();
        check("bp_valid_cleared", 64'(sample_valid_out), 64'd0);
        check("bp_second_start", 64'(den_out), 64'd1);
        check("bp_second_addr", 64'(daddr_out), 64'h14);
        wait_valid("bp_second", 30);
        check("bp_second_volt", 64'(volt_sample_out), 64'h00F);
        step();
        $display("txn backpressure: dropped=%0d", dropped_cnt_out);

        // Host write raised together with eos: sequence first, then host
        eos = 1'b1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 7'h41; host_di = 16'hABCD;
        step();
        eos = 1'b0;
        wait_den("arb_cur", 7'h14, 1'b0, 10);
        wait_den("arb_volt", 7'h1C, 1'b0, 10);
        wait_den("arb_host", 7'h41, 1'b1, 20);
        check("arb_host_di", 64'(di_out), 64'hABCD);
        wait_ack("arb_host", 20);
        host_req = 1'b0; host_we = 1'b0;
        step();
        check("arb_ack_one_cycle", 64'(host_ack_out), 64'd0);
        check("arb_no_reissue", 64'(den_out), 64'd0);
        $display("txn host_write: addr=41 di=abcd");

        // Host read
        host_req = 1'b1; host_addr = 7'h03;
        wait_den("hrd", 7'h03, 1'b0, 10);
        wait_ack("hrd", 20);
        check("hrd_data", 64'(host_do_out), 64'h5A5A);
        host_req = 1'b0;
        step();
        $display("txn host_read: do=%h", host_do_out);

        // Timeout on a silent responder
        resp_en = 1'b0;
        pulse_eos();
        wait_den("tmo_cur", 7'h14, 1'b0, 10);
        n = 0;
        do begin step(); n++; end while (!timeout_err_out && n < 200);
        check("tmo_cycles", 64'(n), 64'd65);
        check("tmo_no_valid", 64'(sample_valid_out), 64'd0);
        check("tmo_idle", 64'(den_out), 64'd0);
        host_req = 1'b1; host_addr = 7'h03;
        wait_den("tmo_host", 7'h03, 1'b0, 10);
        wait_ack("tmo_host", 100);
        check("tmo_host_data", 64'(host_do_out), 64'h0);
        host_req = 1'b0;
        resp_en = 1'b1;
        step();
        pulse_eos();
        wait_den("tmo_retry_cur", 7'h14, 1'b0, 10);
        wait_den("tmo_retry_volt", 7'h1C, 1'b0, 10);
        wait_valid("tmo_retry", 10);
        check("tmo_retry_cur_val", 64'(cur_sample_out), 64'h007);
        check("tmo_sticky", 64'(timeout_err_out), 64'd1);
        step();
        $display("txn timeout: err=%0d", timeout_err_out);

        // Reset in CUR_WAIT with a late drdy afterwards
        pulse_eos();
        wait_den("rst_cur", 7'h14, 1'b0, 10);
        step();
        reset_n = 1'b0;
        step();
        check_all_zero("midreset");
        reset_n = 1'b1;
        den_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (den_out || sample_valid_out) den_seen++;
        end
        check("rst_late_drdy_ignored", 64'(den_seen), 64'd0);
        pulse_eos();
        wait_den("rst_retry_cur", 7'h14, 1'b0, 10);
        wait_den("rst_retry_volt", 7'h1C, 1'b0, 10);
        wait_valid("rst_retry", 10);
        check("rst_retry_cur_val", 64'(cur_sample_out), 64'h007);
        check("rst_retry_volt_val", 64'(volt_sample_out), 64'h00F);
        $display("txn midreset: cur=%h volt=%h", cur_sample_out, volt_sample_out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
